// File: rtl/lc3_controller.sv
// LC3 pipeline control: stage enables, operand bypass selects, data-memory access
// sequencing and branch resolution from the decode (IR) and execute (IR_Exec) instructions.
module lc3_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    input  logic [2:0]  psr,
    input  logic        complete_data,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic [1:0]  mem_state,
    output logic        br_taken
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    localparam logic [1:0] MEM_READ  = 2'd0;
    localparam logic [1:0] MEM_IND   = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;
    localparam logic [1:0] MEM_IDLE  = 2'd3;

    typedef enum logic [1:0] {
        BR_IDLE    = 2'd0,
        BR_EXEC    = 2'd1,
        BR_RESOLVE = 2'd2
    } br_state_t;

    logic [1:0] mem_state_reg;
    br_state_t  br_state_reg;
    logic       exec_new_reg;
    logic       br_taken_reg;

    logic [3:0] ir_op;
    logic [3:0] exec_op;
    logic       ir_is_ctrl;
    logic       exec_is_alu;
    logic       exec_is_load;
    logic       exec_is_store;
    logic       mem_start;
    logic       br_advance;

    assign ir_op         = IR[15:12];
    assign exec_op       = IR_Exec[15:12];
    assign ir_is_ctrl    = (ir_op == OP_BR) || (ir_op == OP_JMP);
    assign exec_is_alu   = (exec_op == OP_ADD) || (exec_op == OP_AND) || (exec_op == OP_NOT);
    assign exec_is_load  = (exec_op == OP_LD) || (exec_op == OP_LDR) || (exec_op == OP_LDI);
    assign exec_is_store = (exec_op == OP_ST) || (exec_op == OP_STR) || (exec_op == OP_STI);

    // Only a freshly loaded IR_Exec may start an access, so a held load/store never repeats.
    assign mem_start  = (mem_state_reg == MEM_IDLE) && exec_new_reg && (exec_is_load || exec_is_store);
    assign br_advance = (mem_state_reg == MEM_IDLE) && !mem_start;

    always_comb begin
        enable_fetch     = 1'b1;
        enable_decode    = 1'b1;
        enable_execute   = 1'b1;
        enable_writeback = 1'b1;
        if (rst) begin
            enable_fetch     = 1'b0;
            enable_decode    = 1'b0;
            enable_execute   = 1'b0;
            enable_writeback = 1'b0;
        end else if (mem_state_reg != MEM_IDLE) begin
            enable_fetch     = 1'b0;
            enable_decode    = 1'b0;
            enable_execute   = 1'b0;
            enable_writeback = (mem_state_reg == MEM_READ) && complete_data;
        end else begin
            case (br_state_reg)
                BR_IDLE: begin
                    enable_fetch = !ir_is_ctrl;
                end
                BR_EXEC: begin
                    enable_fetch  = 1'b0;
                    enable_decode = 1'b0;
                end
                BR_RESOLVE: begin
                    enable_fetch   = 1'b0;
                    enable_decode  = 1'b0;
                    enable_execute = 1'b0;
                end
                default: begin
                    enable_fetch = 1'b1;
                end
            endcase
        end
    end

    // Source operand fields of the decode instruction: index 0 is SR1, index 1 is SR2.
    logic [2:0] src_field [2];
    logic [1:0] src_used;
    logic [1:0] byp_alu;
    logic [1:0] byp_mem;

    assign src_field[0] = IR[8:6];
    assign src_field[1] = ((ir_op == OP_ST) || (ir_op == OP_STR) || (ir_op == OP_STI)) ? IR[11:9] : IR[2:0];

    assign src_used[0] = (ir_op == OP_ADD) || (ir_op == OP_AND) || (ir_op == OP_NOT) ||
                         (ir_op == OP_LDR) || (ir_op == OP_STR) || (ir_op == OP_JMP);
    assign src_used[1] = (((ir_op == OP_ADD) || (ir_op == OP_AND)) && !IR[5]) ||
                         (ir_op == OP_ST) || (ir_op == OP_STR) || (ir_op == OP_STI);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
            logic hit;
            assign hit         = enable_execute && src_used[gi] && (IR_Exec[11:9] == src_field[gi]);
            assign byp_alu[gi] = hit && exec_is_alu;
            assign byp_mem[gi] = hit && exec_is_load && !exec_new_reg;
        end
    endgenerate

    assign bypass_alu_1 = byp_alu[0];
    assign bypass_alu_2 = byp_alu[1];
    assign bypass_mem_1 = byp_mem[0];
    assign bypass_mem_2 = byp_mem[1];
    assign mem_state    = mem_state_reg;
    assign br_taken     = br_taken_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_state_reg <= MEM_IDLE;
            br_state_reg  <= BR_IDLE;
            exec_new_reg  <= 1'b0;
            br_taken_reg  <= 1'b0;
        end else begin
            exec_new_reg <= enable_execute;
            br_taken_reg <= 1'b0;

            case (mem_state_reg)
                MEM_IDLE: begin
                    if (mem_start) begin
                        if (exec_op == OP_LD || exec_op == OP_LDR)
                            mem_state_reg <= MEM_READ;
                        else if (exec_op == OP_LDI || exec_op == OP_STI)
                            mem_state_reg <= MEM_IND;
                        else
                            mem_state_reg <= MEM_WRITE;
                    end
                end
                MEM_IND: begin
                    if (complete_data)
                        mem_state_reg <= (exec_op == OP_LDI) ? MEM_READ : MEM_WRITE;
                end
                default: begin
                    if (complete_data)
                        mem_state_reg <= MEM_IDLE;
                end
            endcase

            if (br_advance) begin
                case (br_state_reg)
                    BR_IDLE: begin
                        if (ir_is_ctrl && enable_decode)
                            br_state_reg <= BR_EXEC;
                    end
                    BR_EXEC: begin
                        br_state_reg <= BR_RESOLVE;
                    end
                    BR_RESOLVE: begin
                        br_taken_reg <= (exec_op == OP_JMP) ? 1'b1 : |(NZP & psr);
                        br_state_reg <= BR_IDLE;
                    end
                    default: begin
                        br_state_reg <= BR_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/lc3_controller.md
Name: lc3_controller

Overview:
Pipeline control unit for the LC3 core. It is the producer side of the execute-stage control interface. It watches the decode-stage instruction (IR) and the instruction latched in execute (IR_Exec). From these it generates the stage enables, the four operand-bypass selects and the memory-access state. It also resolves branches from the execute-stage NZP against the processor status register (psr).

Parameters:
None.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
IR  input  16  instruction currently in decode (next to enter execute)
IR_Exec  input  16  instruction latched in execute stage
NZP  input  3  branch condition from execute (nonzero only for BR)
psr  input  3  current condition codes {N,Z,P}
complete_data  input  1  data memory has finished the current access
enable_fetch  output  1  fetch stage advance
enable_decode  output  1  decode stage advance
enable_execute  output  1  execute stage advance
enable_writeback  output  1  writeback stage advance
bypass_alu_1  output  1  execute src1 takes previous aluout
bypass_alu_2  output  1  execute src2 takes previous aluout
bypass_mem_1  output  1  execute src1 takes memory bypass value
bypass_mem_2  output  1  execute src2 takes memory bypass value
mem_state  output  2  0 read, 1 indirect-address read, 2 write, 3 idle
br_taken  output  1  one-cycle pulse: redirect fetch to pcout

Behaviour:
- Opcode classes (IR[15:12]):
  - ALU = ADD 0001, AND 0101, NOT 1001.
  - LOAD = LD 0010, LDR 0110, LDI 1010.
  - STORE = ST 0011, STR 0111, STI 1011.
  - CTRL = BR 0000, JMP 1100.
- Reset (rst=1 at edge):
  - mem_state=3, branch FSM=BR_IDLE, exec_new=0, br_taken=0.
  - All enables are forced 0 while rst is high.
  - The first cycle after reset has all enables 1.
- exec_new register: set each cycle to the value of enable_execute. It marks IR_Exec as freshly loaded, so a held IR_Exec never re-triggers the memory FSM.
- Memory FSM (mem_state register):
  - Starts only from 3 with exec_new=1:
    - LD/LDR -> 0.
    - LDI/STI -> 1.
    - ST/STR -> 2.
  - Advances only on a cycle with complete_data=1:
    - 0 -> 3.
    - 2 -> 3.
    - 1 -> 0 for LDI, 1 -> 2 for STI.
  - Without complete_data the state holds indefinitely.
- Enables during memory access (mem_state != 3):
  - enable_fetch, enable_decode and enable_execute are 0.
  - enable_writeback = 1 only when mem_state=0 and complete_data=1; otherwise 0.
- Enables with mem_state=3 and branch FSM idle: all four enables are 1.
- Branch FSM (evaluated only when mem_state=3):
  - BR_IDLE -> BR_EXEC when IR is CTRL and enable_decode=1. In that cycle enable_fetch=0.
  - BR_EXEC: enable_fetch=0, enable_decode=0, enable_execute=1 (branch executes; NZP is valid next cycle). Next state is BR_RESOLVE.
  - BR_RESOLVE: enable_fetch=0, enable_decode=0, enable_execute=0.
    - br_taken is registered to |(NZP & psr) for BR, and to 1 for JMP (IR_Exec[15:12]=1100).
    - Next state is BR_IDLE.
  - br_taken is high exactly in the cycle after BR_RESOLVE and is 0 in all other cycles.
  - A memory FSM start freezes the branch FSM until mem_state returns to 3 (memory has priority).
- Bypass selects: combinational, all 0 when enable_execute=0 or rst=1.
  - SR1 users: ADD, AND, NOT, LDR, STR, JMP (field IR[8:6]).
  - SR2 users:
    - ADD/AND with IR[5]=0 (field IR[2:0]).
    - STORE (field IR[11:9]).
  - bypass_alu_x = IR_Exec is ALU, and IR_Exec[11:9] equals the IR source field x.
  - bypass_mem_x = IR_Exec is LOAD, exec_new=0 (the load has completed), and IR_Exec[11:9] equals the IR source field x.
  - The alu and mem bypass for the same source are mutually exclusive, because the opcode classes are disjoint.

Test Plan:
1. Reset, then deassert rst. Cycle 0 enables=0. Cycle 1: enables all 1, mem_state=3, br_taken=0, all bypass=0.
2. IR_Exec=ADD R1,R2,R3 (0x1283) with IR=ADD R4,R1,R1 (0x1841) -> bypass_alu_1=1 and bypass_alu_2=1. With IR=0x1862 (ADD R4,R1,#2), bypass_alu_2=0.
3. IR_Exec=LDI R2 (0xA405) freshly loaded, complete_data pulsed every 3rd cycle:
   - mem_state goes 1 -> 0 -> 3, each state held until the complete_data pulse.
   - Fetch/decode/execute stay 0 throughout.
   - enable_writeback=1 for one cycle at the 0->3 transition.
4. Continuing from 3 with IR=ADD R5,R2,#1 (0x1AA1): the first cycle after mem_state=3 has bypass_mem_1=1 and enable_execute=1. The memory FSM does not restart.
5. IR=BRz (0x0403) with psr=3'b010, resulting NZP=3'b010:
   - enable_fetch low for 3 cycles; enable_decode low for 2.
   - br_taken=1 for exactly one cycle.
   - Repeat with psr=3'b001: br_taken stays 0.
6. rst asserted while mem_state=1 and the branch FSM is in BR_EXEC: next cycle mem_state=3, branch FSM idle, br_taken=0, all enables 0 until rst drops.
